// File: rtl/booth_div_32_16_pkg.sv
// Shared types and constants for the 32/16 signed restoring divider.
package booth_div_32_16_pkg;

    localparam int DW    = 16;
    localparam int NW    = 2 * DW;
    localparam int ITERS = NW;

    localparam logic [DW-1:0] QMAX = 16'h7FFF;
    localparam logic [DW-1:0] QMIN = 16'h8000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        SIGN = 2'd2,
        ZERO = 2'd3
    } state_e;

endpackage

// File: rtl/inv_converter_16.sv
// 16-bit conditional two's-complement negation, shared with the multiplier datapath.
module inv_converter_16
    import booth_div_32_16_pkg::*;
(
    input  logic [DW-1:0] a_i,
    input  logic          neg_i,
    output logic [DW-1:0] y_o
);

    assign y_o = neg_i ? (~a_i + 1'b1) : a_i;

endmodule

// File: rtl/booth_div_32_16.sv
// Iterative signed divider: magnitudes through 32 restoring steps, then sign fix-up.
module booth_div_32_16
    import booth_div_32_16_pkg::*;
(
    input  logic          sys_clk,
    input  logic          sys_rst,
    input  logic          valid_i,
    output logic          ready_o,
    input  logic [31:0]   dividend_i,
    input  logic [15:0]   divisor_i,
    output logic          valid_o,
    output logic [15:0]   quot_o,
    output logic [15:0]   rem_o,
    output logic          ovf_o,
    output logic          dz_o
);

    state_e        state_q, state_d;
    logic          dvd_neg_q, dvd_neg_d;
    logic          dsr_neg_q, dsr_neg_d;
    logic [NW-1:0] acc_q, acc_d;
    logic [DW-1:0] dsr_q, dsr_d;
    logic [DW:0]   prem_q, prem_d;
    logic [4:0]    cnt_q, cnt_d;
    logic          valid_q, valid_d;
    logic [DW-1:0] quot_q, quot_d;
    logic [DW-1:0] rem_q, rem_d;
    logic          ovf_q, ovf_d;
    logic          dz_q, dz_d;

    logic [NW-1:0] dvd_abs;
    logic [DW+1:0] trial;
    logic [DW+2:0] diff;
    logic          q_neg;
    logic          q_ovf;
    logic [DW-1:0] cv0_a, cv0_y, cv1_y;
    logic          cv0_neg;

    // Converter 0 takes |divisor| on acceptance and fixes the remainder sign in SIGN.
    assign cv0_a   = (state_q == SIGN) ? prem_q[DW-1:0] : divisor_i;
    assign cv0_neg = (state_q == SIGN) ? dvd_neg_q      : divisor_i[DW-1];

    inv_converter_16 u_cv_shared (.a_i(cv0_a), .neg_i(cv0_neg), .y_o(cv0_y));
    inv_converter_16 u_cv_quot   (.a_i(acc_q[DW-1:0]), .neg_i(q_neg), .y_o(cv1_y));

    assign dvd_abs = dividend_i[NW-1] ? (~dividend_i + 1'b1) : dividend_i;
    // acc_q starts as the dividend magnitude and fills with quotient bits from the LSB.
    assign trial   = {prem_q, acc_q[NW-1]};
    assign diff    = {1'b0, trial} - {3'b000, dsr_q};
    assign q_neg   = dvd_neg_q ^ dsr_neg_q;
    assign q_ovf   = q_neg ? (acc_q > 32'd32768) : (acc_q > 32'd32767);

    always_comb begin
        state_d   = state_q;
        dvd_neg_d = dvd_neg_q;
        dsr_neg_d = dsr_neg_q;
        acc_d     = acc_q;
        dsr_d     = dsr_q;
        prem_d    = prem_q;
        cnt_d     = cnt_q;
        valid_d   = 1'b0;
        quot_d    = quot_q;
        rem_d     = rem_q;
        ovf_d     = ovf_q;
        dz_d      = dz_q;
        case (state_q)
            IDLE: begin
                if (valid_i) begin
                    dvd_neg_d = dividend_i[NW-1];
                    dsr_neg_d = divisor_i[DW-1];
                    acc_d     = dvd_abs;
                    dsr_d     = cv0_y;
                    prem_d    = '0;
                    cnt_d     = '0;
                    state_d   = (divisor_i == '0) ? ZERO : CALC;
                end
            end
            CALC: begin
                cnt_d = cnt_q + 5'd1;
                if (!diff[DW+2]) begin
                    prem_d = diff[DW:0];
                    acc_d  = {acc_q[NW-2:0], 1'b1};
                end else begin
                    prem_d = trial[DW:0];
                    acc_d  = {acc_q[NW-2:0], 1'b0};
                end
                if (cnt_q == 5'(ITERS - 1)) state_d = SIGN;
            end
            SIGN: begin
                valid_d = 1'b1;
                dz_d    = 1'b0;
                ovf_d   = q_ovf;
                quot_d  = q_ovf ? (q_neg ? QMIN : QMAX) : cv1_y;
                rem_d   = cv0_y;
                state_d = IDLE;
            end
            ZERO: begin
                valid_d = 1'b1;
                dz_d    = 1'b1;
                ovf_d   = 1'b0;
                quot_d  = '0;
                rem_d   = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q   <= IDLE;
            dvd_neg_q <= 1'b0;
            dsr_neg_q <= 1'b0;
            acc_q     <= '0;
            dsr_q     <= '0;
            prem_q    <= '0;
            cnt_q     <= '0;
            valid_q   <= 1'b0;
            quot_q    <= '0;
            rem_q     <= '0;
            ovf_q     <= 1'b0;
            dz_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            dvd_neg_q <= dvd_neg_d;
            dsr_neg_q <= dsr_neg_d;
            acc_q     <= acc_d;
            dsr_q     <= dsr_d;
            prem_q    <= prem_d;
            cnt_q     <= cnt_d;
            valid_q   <= valid_d;
            quot_q    <= quot_d;
            rem_q     <= rem_d;
            ovf_q     <= ovf_d;
            dz_q      <= dz_d;
        end
    end

    assign ready_o = (state_q == IDLE);
    assign valid_o = valid_q;
    assign quot_o  = quot_q;
    assign rem_o   = rem_q;
    assign ovf_o   = ovf_q;
    assign dz_o    = dz_q;

endmodule

// File: tb/tb_booth_div_32_16.sv
// Randomized bench for booth_div_32_16 against a plain signed-arithmetic reference.
module tb_booth_div_32_16;

    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b1;
    logic        valid_i = 1'b0;
    logic        ready_o;
    logic [31:0] dividend_i = '0;
    logic [15:0] divisor_i = '0;
    logic        valid_o;
    logic [15:0] quot_o;
    logic [15:0] rem_o;
    logic        ovf_o;
    logic        dz_o;

    int checks = 0;
    int errors = 0;

    booth_div_32_16 dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .valid_i(valid_i), .ready_o(ready_o),
        .dividend_i(dividend_i), .divisor_i(divisor_i), .valid_o(valid_o),
        .quot_o(quot_o), .rem_o(rem_o), .ovf_o(ovf_o), .dz_o(dz_o)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    // Reference: truncating signed division, remainder follows dividend, saturate on overflow.
    task automatic model(input logic [31:0] dvd, input logic [15:0] dsr,
                         output logic [15:0] q, output logic [15:0] r,
                         output logic ovf, output logic dz);
        longint a, b, qq, rr;
        a = longint'($signed(dvd));
        b = longint'($signed(dsr));
        dz = (b == 0);
        ovf = 1'b0;
        q = '0;
        r = '0;
        if (!dz) begin
            qq = a / b;
            rr = a % b;
            r  = rr[15:0];
            if (qq > 32767)       begin ovf = 1'b1; q = 16'h7FFF; end
            else if (qq < -32768) begin ovf = 1'b1; q = 16'h8000; end
            else                  q = qq[15:0];
        end
    endtask

    task automatic run(input logic [31:0] dvd, input logic [15:0] dsr);
        logic [15:0] eq, er;
        logic        eo, ez;
        int          n;
        bit          busy_ok;
        model(dvd, dsr, eq, er, eo, ez);
        n = 0;
        while (!ready_o && n < 100) begin @(posedge sys_clk); #1; n++; end
        dividend_i = dvd;
        divisor_i  = dsr;
        valid_i    = 1'b1;
        @(posedge sys_clk); #1;
        chk("rdy_after_xfer", 32'(ready_o), 32'd0);
        chk("vld_after_xfer", 32'(valid_o), 32'd0);
        // Garbage with valid held high while busy must be ignored.
        dividend_i = $urandom;
        divisor_i  = 16'($urandom);
        n = 1;
        busy_ok = 1'b1;
        while (!valid_o && n < 100) begin
            if (ready_o) busy_ok = 1'b0;
            @(posedge sys_clk); #1;
            n++;
        end
        valid_i = 1'b0;
        if (!valid_o) begin
            chk("timeout", 32'(valid_o), 32'd1);
            return;
        end
        chk("busy_low", 32'(busy_ok), 32'd1);
        chk("latency", 32'(n), ez ? 32'd2 : 32'd34);
        chk("rdy_at_vld", 32'(ready_o), 32'd1);
        chk("quot", 32'(quot_o), 32'(eq));
        chk("rem", 32'(rem_o), 32'(er));
        chk("ovf", 32'(ovf_o), 32'(eo));
        chk("dz", 32'(dz_o), 32'(ez));
    endtask

    initial begin
        logic [31:0] d;
        logic [15:0] s;
        int          seen;
        repeat (3) @(posedge sys_clk);
        #1 sys_rst = 1'b0;
        chk("rst_ready", 32'(ready_o), 32'd1);
        chk("rst_valid", 32'(valid_o), 32'd0);
        chk("rst_quot", 32'(quot_o), 32'd0);
        chk("rst_rem", 32'(rem_o), 32'd0);
        chk("rst_flags", {30'd0, ovf_o, dz_o}, 32'd0);

        run(32'd1000, 16'd7);
        run(32'hFFFFFC18, 16'd7);
        run(32'h40000000, 16'h8000);
        run(32'h40000000, 16'h7FFF);
        run(32'h80000000, 16'hFFFF);
        run(32'd12345, 16'd0);
        run(32'd77777, 16'hFFF3);   // issued on the edge right after the divide-by-zero result

        // Abort in the 10th CALC cycle.
        run(32'd1000, 16'd7);
        dividend_i = 32'd1000;
        divisor_i  = 16'd7;
        valid_i    = 1'b1;
        @(posedge sys_clk); #1;
        valid_i = 1'b0;
        repeat (9) @(posedge sys_clk);
        #1 sys_rst = 1'b1;
        @(posedge sys_clk); #1;
        sys_rst = 1'b0;
        chk("abort_ready", 32'(ready_o), 32'd1);
        chk("abort_valid", 32'(valid_o), 32'd0);
        chk("abort_quot", 32'(quot_o), 32'd0);
        chk("abort_rem", 32'(rem_o), 32'd0);
        chk("abort_flags", {30'd0, ovf_o, dz_o}, 32'd0);
        seen = 0;
        repeat (40) begin @(posedge sys_clk); #1; if (valid_o) seen++; end
        chk("abort_no_vld", 32'(seen), 32'd0);
        run(32'd100, 16'hFFFD);

        for (int i = 0; i < 60; i++) begin
            case ($urandom_range(0, 3))
                0: begin d = $urandom; s = 16'($urandom); end
                1: begin
                    s = 16'($urandom);
                    d = 32'($signed(16'($urandom)) * $signed(s));
                end
                2: begin d = $urandom; s = 16'($urandom_range(1, 255)) ^ {16{d[0]}}; end
                default: begin d = $urandom_range(0, 3) == 0 ? 32'd0 : $urandom; s = 16'($urandom_range(0, 2)); end
            endcase
            run(d, s);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout");
        $fatal(1);
    end

endmodule
